// File: rtl/sha2_msg_sched_pkg.sv
// sha2_pkg: shared constants, FSM state type and sigma rotation/shift table
// for the SHA-2 message-schedule expander (SHA-256 and SHA-512 word sizes).
package sha2_pkg;

    // Depth of the sliding window holding W[t-16..t-1]
    localparam int WIN_DEPTH = 16;

    // Width of the schedule index (covers up to 127 rounds)
    localparam int IDX_W = 7;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sched_state_t;

    // Rotation/shift amounts for the small sigmas.
    // sel: 0 = sigma0, 1 = sigma1.
    // k:   0 = first rotate, 1 = second rotate, 2 = logical right shift.
    function automatic int sigma_amt(input int word_w, input int sel, input int k);
        int amt;
        amt = 0;
        if (word_w == 64) begin
            if (sel == 0) amt = (k == 0) ? 1  : (k == 1) ? 8  : 7;
            else          amt = (k == 0) ? 19 : (k == 1) ? 61 : 6;
        end else begin
            if (sel == 0) amt = (k == 0) ? 7  : (k == 1) ? 18 : 3;
            else          amt = (k == 0) ? 17 : (k == 1) ? 19 : 10;
        end
        return amt;
    endfunction

endpackage

// File: rtl/sha2_msg_sched_if.sv
// Stream interface of the message-schedule expander: message words in,
// schedule words (with index and last flag) out.
interface sha2_msg_sched_if #(parameter int WORD_W = 32);

    logic                      in_valid;
    logic                      in_ready;
    logic [WORD_W-1:0]         in_word;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_word;
    logic [sha2_pkg::IDX_W-1:0] out_idx;
    logic                      out_last;

    // Producer of message words / consumer of schedule words
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last
    );

    // The expander itself
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last
    );

endinterface

// File: rtl/sha2_msg_sched_sigma.sv
// sha2_sigma: combinational SHA-2 small sigma. SEL=0 gives sigma0,
// SEL=1 gives sigma1; rotate/shift amounts follow WORD_W (32 or 64).
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int ROT_A = sigma_amt(WORD_W, SEL, 0);
    localparam int ROT_B = sigma_amt(WORD_W, SEL, 1);
    localparam int SHR_C = sigma_amt(WORD_W, SEL, 2);

    assign y = ((x >> ROT_A) | (x << (WORD_W - ROT_A)))
             ^ ((x >> ROT_B) | (x << (WORD_W - ROT_B)))
             ^ (x >> SHR_C);

endmodule

// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-2 message-schedule expander. Takes the 16 message
// words of a block and streams W[0..ROUNDS-1] through a one-deep output slot.
// Optional build macro SHA2_SCHED_PIPE_EN registers sigma1(W[t-2]) + W[t-7]
// in a pre-sum stage, halving EXPAND throughput to one word per 2 cycles.
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    sha2_msg_sched_if.slave     bus,
    output logic                busy
);

    generate
        if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
            $error("sha2_msg_sched: WORD_W must be 32 or 64");
        end
        if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
            $error("sha2_msg_sched: ROUNDS must be in 16..127");
        end
    endgenerate

    localparam logic [IDX_W-1:0] ROUNDS_C = IDX_W'(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(WIN_DEPTH - 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [WORD_W-1:0]  win [WIN_DEPTH];
    logic [IDX_W-1:0]   count;

    logic               slot_free;
    logic               done;
    logic               load_fire;
    logic               exp_fire;
    logic               last_fire;
    logic               pre_ok;

    logic [WORD_W-1:0]  s0_w;
    logic [WORD_W-1:0]  s1_w;
    logic [WORD_W-1:0]  w_new;
    logic [WORD_W-1:0]  next_word;
    logic [IDX_W-1:0]   next_idx;

    sha2_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
        .x (win[1]),
        .y (s0_w)
    );

    sha2_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
        .x (win[WIN_DEPTH-2]),
        .y (s1_w)
    );

`ifdef SHA2_SCHED_PIPE_EN
    logic [WORD_W-1:0] pre_sum;
    logic              pre_valid;

    // Pre-sum stage: capture sigma1(W[t-2]) + W[t-7] once per expanded word;
    // the window is frozen until that word is emitted, so the term stays valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_sum   <= '0;
            pre_valid <= 1'b0;
        end else if (clr || exp_fire) begin
            pre_valid <= 1'b0;
        end else if (state == EXPAND && !done && !pre_valid) begin
            pre_sum   <= s1_w + win[WIN_DEPTH-7];
            pre_valid <= 1'b1;
        end
    end

    assign pre_ok = pre_valid;
    assign w_new  = pre_sum + s0_w + win[0];
`else
    assign pre_ok = 1'b1;
    assign w_new  = s1_w + win[WIN_DEPTH-7] + s0_w + win[0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    // Next state: LOAD until the 16th message word, EXPAND until the last
    // schedule word is handed off (a new M[0] may be taken in that same cycle)
    always_comb begin
        state_next = state;
        if (clr)                                state_next = LOAD;
        else if (last_fire)                     state_next = LOAD;
        else if (load_fire && count == LOAD_END) state_next = EXPAND;
    end

    // Handshake and control decode
    always_comb begin
        slot_free    = !bus.out_valid || bus.out_ready;
        done         = (count == ROUNDS_C);
        bus.in_ready = slot_free && ((state == LOAD) || done);
        load_fire    = bus.in_valid && bus.in_ready && !clr;
        exp_fire     = (state == EXPAND) && !done && slot_free && pre_ok && !clr;
        last_fire    = bus.out_valid && bus.out_ready && bus.out_last && !clr;
        busy         = (count != '0) || bus.out_valid;
        next_word    = load_fire ? bus.in_word : w_new;
        next_idx     = (load_fire && done) ? '0 : count;
    end

    // Window, count and output slot: a new word (message or expanded) shifts
    // into the window and the slot together; a bare handshake empties the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_word  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
        end else if (clr) begin
            count         <= '0;
            bus.out_valid <= 1'b0;
        end else if (load_fire || exp_fire) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) win[i] <= win[i+1];
            win[WIN_DEPTH-1] <= next_word;
            count         <= next_idx + IDX_W'(1);
            bus.out_valid <= 1'b1;
            bus.out_word  <= next_word;
            bus.out_idx   <= next_idx;
            bus.out_last  <= (next_idx == LAST_IDX);
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.out_last) count <= '0;
        end
    end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb_sha2_msg_sched: scoreboard bench for the SHA-2 message-schedule
// expander, with a SHA-256 instance and a SHA-512 instance.
module tb_sha2_msg_sched;

`ifdef SHA2_SCHED_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] word;
        logic [6:0]  idx;
        logic        last;
    } sb_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic busy32;
    logic busy64;

    sha2_msg_sched_if #(.WORD_W(32)) if32 ();
    sha2_msg_sched_if #(.WORD_W(64)) if64 ();

    sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (if32),
        .busy  (busy32)
    );

    sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (if64),
        .busy  (busy64)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   first_cyc  = 0;
    int   last_cyc32 = 0;
    int   last_cyc64 = 0;
    bit   bp_en      = 1'b0;
    bit   ready_val  = 1'b1;
    bit   abc_chk32  = 1'b0;
    bit   abc_chk64  = 1'b0;
    logic [63:0] blk [16];
    sb_t  q32[$];
    sb_t  q64[$];
    sb_t  held32;
    sb_t  held64;
    bit   held32_v = 1'b0;
    bit   held64_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference sigma functions
    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [31:0] s0_32(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] s1_32(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] s0_64(input logic [63:0] x);
        return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] s1_64(input logic [63:0] x);
        return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    endfunction

    function automatic int expCycles(input int rounds);
        return PIPE ? (2 * rounds - 15) : (rounds + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Out_ready driver: random 50% when bp_en, else the level in ready_val
    initial begin
        forever begin
            if32.out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_val;
            if64.out_ready = ready_val;
            @(posedge clk);
            #1;
        end
    end

    // Monitor for the 32-bit instance
    always @(negedge clk) begin : mon32
        sb_t act;
        sb_t e;
        if (!rst_n || !if32.out_valid) begin
            held32_v = 1'b0;
        end else begin
            act.word = 64'(if32.out_word);
            act.idx  = if32.out_idx;
            act.last = if32.out_last;
            if (if32.out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb32_unexpected: got word idx %0d, expected no output", act.idx);
                end else begin
                    e = q32.pop_front();
                    checkOutput("sb32_word_idx_last", 128'(act), 128'(e));
                end
                if (abc_chk32) begin
                    if (act.idx == 7'd16) checkOutput("abc32_w16", 128'(act.word), 128'h61626380);
                    if (act.idx == 7'd17) checkOutput("abc32_w17", 128'(act.word), 128'h000F0000);
                    if (act.idx == 7'd18) checkOutput("abc32_w18", 128'(act.word), 128'h7DA86405);
                    if (act.last)         checkOutput("abc32_last_idx", 128'(act.idx), 128'd63);
                end
                if (act.last) last_cyc32 = cyc + 1;
                held32_v = 1'b0;
            end else begin
                if (held32_v) checkOutput("stall32_stable", 128'(act), 128'(held32));
                held32   = act;
                held32_v = 1'b1;
            end
        end
    end

    // Monitor for the 64-bit instance
    always @(negedge clk) begin : mon64
        sb_t act;
        sb_t e;
        if (!rst_n || !if64.out_valid) begin
            held64_v = 1'b0;
        end else begin
            act.word = if64.out_word;
            act.idx  = if64.out_idx;
            act.last = if64.out_last;
            if (if64.out_ready) begin
                if (q64.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb64_unexpected: got word idx %0d, expected no output", act.idx);
                end else begin
                    e = q64.pop_front();
                    checkOutput("sb64_word_idx_last", 128'(act), 128'(e));
                end
                if (abc_chk64) begin
                    if (act.idx == 7'd16) checkOutput("abc64_w16", 128'(act.word), 128'h6162638000000000);
                    if (act.idx == 7'd17) checkOutput("abc64_w17", 128'(act.word), 128'h00030000000000C0);
                    if (act.last)         checkOutput("abc64_last_idx", 128'(act.idx), 128'd79);
                end
                if (act.last) last_cyc64 = cyc + 1;
                held64_v = 1'b0;
            end else begin
                if (held64_v) checkOutput("stall64_stable", 128'(act), 128'(held64));
                held64   = act;
                held64_v = 1'b1;
            end
        end
    end

    // Push the expected schedule of the block in blk[] onto a scoreboard
    task automatic pushBlock(input int sel, input int rounds);
        logic [63:0] w [128];
        sb_t e;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16)
                w[t] = (sel == 0) ? {32'h0, blk[t][31:0]} : blk[t];
            else if (sel == 0)
                w[t] = {32'h0, s1_32(w[t-2][31:0]) + w[t-7][31:0] + s0_32(w[t-15][31:0]) + w[t-16][31:0]};
            else
                w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
            e.word = w[t];
            e.idx  = 7'(t);
            e.last = (t == rounds - 1);
            if (sel == 0) q32.push_back(e);
            else          q64.push_back(e);
        end
    endtask

    // Feed the 16 words of blk[] into the chosen instance (entered at posedge+1)
    task automatic applyStimulus(input int sel, input bit b2b_chk, input bit hold_valid);
        bit acc;
        int guard;
        for (int i = 0; i < 16; i++) begin
            if (sel == 0) begin
                if32.in_valid = 1'b1;
                if32.in_word  = blk[i][31:0];
            end else begin
                if64.in_valid = 1'b1;
                if64.in_word  = blk[i];
            end
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 1000) begin
                @(negedge clk);
                acc = (sel == 0) ? (if32.in_ready && !clr) : (if64.in_ready && !clr);
                if (acc && i == 0) begin
                    first_cyc = cyc + 1;
                    if (b2b_chk)
                        checkOutput("b2b_m0_on_last", 128'({if32.out_valid, if32.out_ready, if32.out_last}), 128'(3'b111));
                end
                guard++;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL accept_timeout: word %0d not accepted, expected acceptance within 1000 cycles", i);
                break;
            end
        end
        if (!hold_valid) begin
            if32.in_valid = 1'b0;
            if64.in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input int sel, input int budget);
        int left;
        for (int g = 0; g < budget; g++) begin
            left = (sel == 0) ? q32.size() : q64.size();
            if (left == 0) break;
            @(posedge clk);
            #1;
        end
        left = (sel == 0) ? q32.size() : q64.size();
        if (left != 0) checkOutput("drain_timeout_words_left", 128'(left), 128'd0);
    endtask

    task automatic waitIdx32(input int idx, input string name);
        bit seen;
        seen = 1'b0;
        for (int g = 0; g < 500 && !seen; g++) begin
            @(negedge clk);
            seen = if32.out_valid && (if32.out_idx == 7'(idx));
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: out_idx %0d never seen, expected within 500 cycles", name, idx);
        end
    endtask

    task automatic checkReset32(input string tag);
        checkOutput({tag, "_out_valid"}, 128'(if32.out_valid), 128'd0);
        checkOutput({tag, "_out_word"},  128'(if32.out_word),  128'd0);
        checkOutput({tag, "_out_idx"},   128'(if32.out_idx),   128'd0);
        checkOutput({tag, "_out_last"},  128'(if32.out_last),  128'd0);
        checkOutput({tag, "_in_ready"},  128'(if32.in_ready),  128'd1);
        checkOutput({tag, "_busy"},      128'(busy32),         128'd0);
    endtask

    task automatic setAbc32();
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = 64'h61626380;
        blk[15] = 64'h18;
    endtask

    initial begin
        rst_n         = 1'b1;
        clr           = 1'b0;
        if32.in_valid = 1'b0;
        if32.in_word  = '0;
        if64.in_valid = 1'b0;
        if64.in_word  = '0;
        #1 rst_n = 1'b0;
        #2;
        $display("[TB] reset state");
        checkReset32("reset");
        checkOutput("reset64_out_valid", 128'(if64.out_valid), 128'd0);
        checkOutput("reset64_in_ready",  128'(if64.in_ready),  128'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] SHA-256 abc block, out_ready held high");
        setAbc32();
        abc_chk32 = 1'b1;
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitDrain(0, 400);
        checkOutput("abc32_cycles", 128'(last_cyc32 - first_cyc + 1), 128'(expCycles(64)));
        checkOutput("abc32_idle_busy", 128'(busy32), 128'd0);

        $display("[TB] SHA-256 abc block with random backpressure");
        bp_en = 1'b1;
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitDrain(0, 2000);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back blocks");
        abc_chk32 = 1'b0;
        setAbc32();
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) blk[i] = 64'(32'h01010101 * i);
        blk[0]  = 64'h12345678;
        blk[5]  = 64'hDEADBEEF;
        blk[15] = 64'h80;
        pushBlock(0, 64);
        applyStimulus(0, 1'b1, 1'b0);
        waitDrain(0, 800);

        $display("[TB] clr while stalled at count 30");
        setAbc32();
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitIdx32(28, "clr_reach_idx28");
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 10 && !if32.out_valid; g++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("clr_held_idx", 128'(if32.out_idx), 128'd29);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_out_valid", 128'(if32.out_valid), 128'd0);
        checkOutput("clr_in_ready",  128'(if32.in_ready),  128'd1);
        checkOutput("clr_busy",      128'(busy32),         128'd0);
        q32.delete();
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        abc_chk32 = 1'b1;
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitDrain(0, 400);

        $display("[TB] asynchronous reset mid-EXPAND");
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitIdx32(20, "rst_reach_idx20");
        #2 rst_n = 1'b0;
        #1 checkReset32("midreset");
        q32.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushBlock(0, 64);
        applyStimulus(0, 1'b0, 1'b0);
        waitDrain(0, 400);
        checkOutput("abc32_after_reset_cycles", 128'(last_cyc32 - first_cyc + 1), 128'(expCycles(64)));
        abc_chk32 = 1'b0;

        $display("[TB] SHA-512 abc block");
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = 64'h6162638000000000;
        blk[15] = 64'h18;
        abc_chk64 = 1'b1;
        pushBlock(1, 80);
        applyStimulus(1, 1'b0, 1'b0);
        waitDrain(1, 800);
        checkOutput("abc64_cycles", 128'(last_cyc64 - first_cyc + 1), 128'(expCycles(80)));
        checkOutput("abc64_idle_busy", 128'(busy64), 128'd0);
        abc_chk64 = 1'b0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha2_msg_sched.md
# sha2_msg_sched

Parametrised SHA-2 message-schedule expander. It accepts the 16 words of one message block and streams out the full schedule W[0..ROUNDS-1] to the compression round engine, one word per output handshake. It is the sequential successor of the fixed 32-bit small-sigma datapath. It supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) through parameters.

## Interface
- WORD_W, 32, word width; legal values are 32 and 64 only, and any other value is an elaboration error.
- ROUNDS, 64, number of schedule words emitted per block; must be at least 16 and at most 127.
- clk  in  1  the single clock of the block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous soft clear that abandons the current block.
- in_valid  in  1  in_word holds a message word.
- in_ready  out  1  the block accepts a word this cycle.
- in_word  in  WORD_W  message word M[t], t = 0..15, big-endian word order.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  the consumer takes out_word this cycle.
- out_word  out  WORD_W  schedule word W[t].
- out_idx  out  7  the index t of out_word.
- out_last  out  1  high when out_idx == ROUNDS-1.
- busy  out  1  a block is in progress, i.e. count != 0 or out_valid.

## Operation
- Storage is a 16-word window holding W[t-16..t-1] as a shift register, plus a 7-bit count and a registered output slot (out_word, out_idx, out_valid).
- Sigma functions, for WORD_W=32:
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10
- Sigma functions, for WORD_W=64:
  - σ0 = ROTR1 ^ ROTR8 ^ SHR7
  - σ1 = ROTR19 ^ ROTR61 ^ SHR6
- Expansion: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed modulo 2^WORD_W. Carries are discarded.
- The slot is free when !out_valid || out_ready.
- State LOAD (count < 16):
  - in_ready = slot free.
  - On accept, in_word enters the window and the slot loads {in_word, count}; count then increments.
- State EXPAND (16 <= count < ROUNDS):
  - in_ready = 0.
  - When the slot is free, the computed W[count] loads into the slot and shifts into the window; count then increments.
- When count reaches ROUNDS, no further words are generated.
- After the handshake of the word with out_last, count returns to 0 and the state returns to LOAD.
- The output is stalled whenever out_valid && !out_ready. While stalled, out_word, out_idx and out_last stay stable, and the window and count stay frozen.
- clr has priority over all handshakes in the same cycle. It sets count to 0 and out_valid to 0 and selects LOAD. A word presented with in_valid in that cycle is dropped. Window contents do not need clearing.

## Timing
- Reset values: out_valid=0, out_word=0, out_idx=0, out_last=0, in_ready=1, busy=0, count=0, and every window word = 0.
- rst_n asserted mid-block aborts the block immediately, asynchronously. Operation resumes in LOAD on the first rising edge after release.
- Input-to-output latency is 1 cycle: a word accepted at edge k has out_valid high after edge k.
- The first expanded word, W[16], loads in the same edge that W[15] is consumed.
- With in_valid=1 and out_ready=1 held constantly, the block emits one word per cycle: ROUNDS words in ROUNDS+1 cycles from the first accept.
- A new block's M[0] is accepted in the same cycle that the out_last word is consumed.

## Configuration
- The macro is SHA2_SCHED_PIPE_EN.
- When defined:
  - The term σ1(W[t-2]) + W[t-7] is registered in a pre-sum stage, so each expanded word needs 2 cycles. EXPAND throughput becomes one word per 2 cycles.
  - The pre-sum stage is flushed by clr and reset.
  - LOAD timing is unchanged.
- When undefined, the full sum is combinational and throughput is one word per cycle, as specified in Timing.
- Output values are identical in both builds; only the cycle spacing in EXPAND differs.

## Structure
- sha2_pkg holds:
  - the rotation/shift constant function indexed by WORD_W;
  - the state enum {LOAD, EXPAND};
  - the window depth constant 16;
  - the index width constant 7.
- The sub-module sha2_sigma(WORD_W, SEL) is a combinational σ0/σ1 selected by the SEL parameter. It is instantiated twice.

## Test plan
- SHA-256 "abc" block:
  - Stimulus: M0=0x61626380, M1..M14=0, M15=0x00000018, out_ready=1.
  - Required: W16=0x61626380, W17=0x000F0000, out_last only at idx 63, 64 words in 65 cycles.
- Backpressure: toggle out_ready with a random 50% pattern on the "abc" block. The word sequence must match the unstalled run, with no duplicated or skipped index. The held word must be stable while stalled.
- Back-to-back blocks: keep in_valid high across two blocks. The second block's M0 must be accepted in the out_last handshake cycle, and its out_idx must restart at 0.
- clr at count=30 while stalled: out_valid must fall to 0 on the next edge and in_ready must be 1. A fresh block must then produce the correct W16.
- rst_n pulse asynchronously mid-EXPAND: all outputs must take their reset values before the next edge. A following "abc" block must be correct.
- WORD_W=64, ROUNDS=80, SHA-512 "abc":
  - Stimulus: M0=0x6162638000000000, M15=0x18.
  - Required: W16=0x6162638000000000, out_last at idx 79.
  - Run under both SHA2_SCHED_PIPE_EN builds, which must give the same words, with 2-cycle spacing in EXPAND when the macro is defined.
